// File: rtl/meas_sequencer.sv
// meas_sequencer: drives the measurement FIFO control pins through one capture:
// clear the FIFO, skip the ADC pipeline samples, write a fixed number of samples,
// then hand the FIFO over to the SPI readout.
`timescale 1ns/1ps
module meas_sequencer #(
    parameter int unsigned MEAS_POINTS    = 4096,
    parameter int unsigned CLEAR_CYCLES   = 2,
    parameter int unsigned SETTLE_SAMPLES = 4
) (
    input  logic        sys_clk,
    input  logic        rst,
    input  logic        start_meas,
    input  logic        start_read,
    input  logic        abort,
    input  logic        adc_conv_clk,
    input  logic        fifo_full,
    input  logic        fifo_empty,
    output logic        fifo_clear,
    output logic        fifo_wr_en,
    output logic        fifo_rd_en,
    output logic        busy,
    output logic        meas_done,
    output logic        cmd_rejected,
    output logic [12:0] point_cnt
);

    localparam int unsigned PCW = 13;
    localparam int unsigned CLW = (CLEAR_CYCLES > 1) ? $clog2(CLEAR_CYCLES) : 1;
    localparam int unsigned SW  = 4;
    localparam logic [PCW-1:0] MEAS_MAX  = PCW'(MEAS_POINTS);
    localparam logic [CLW-1:0] CLR_LAST  = CLW'(CLEAR_CYCLES - 1);
    localparam logic [SW-1:0]  SETTLE_N  = SW'(SETTLE_SAMPLES);

    typedef enum logic [2:0] {
        S_IDLE, S_CLEAR, S_SETTLE, S_CAPTURE, S_DONE, S_READ
    } state_t;

    state_t         state_q, state_d;
    logic           clear_q, clear_d;
    logic           wr_q, wr_d;
    logic           rd_q, rd_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic           rej_q, rej_d;
    logic [PCW-1:0] pcnt_q, pcnt_d;
    logic [CLW-1:0] clr_cnt_q, clr_cnt_d;
    logic [SW-1:0]  settle_cnt_q, settle_cnt_d;

    logic conv_s1_q, conv_s2_q, conv_h_q;
    logic conv_fall, conv_rise;
    logic [PCW-1:0] pcnt_inc;

    // Edge strobes from the synchronised conversion clock (act on the third sys_clk edge after the pin edge)
    assign conv_fall = conv_h_q & ~conv_s2_q;
    assign conv_rise = ~conv_h_q & conv_s2_q;
    assign pcnt_inc  = (pcnt_q == MEAS_MAX) ? pcnt_q : pcnt_q + PCW'(1);

    // Two-flop synchroniser plus history flop for adc_conv_clk
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            conv_s1_q <= 1'b0;
            conv_s2_q <= 1'b0;
            conv_h_q  <= 1'b0;
        end else begin
            conv_s1_q <= adc_conv_clk;
            conv_s2_q <= conv_s1_q;
            conv_h_q  <= conv_s2_q;
        end
    end

    // Next-state and registered-output decode; abort overrides everything
    always_comb begin
        state_d      = state_q;
        clear_d      = 1'b0;
        wr_d         = 1'b0;
        rd_d         = 1'b0;
        done_d       = 1'b0;
        rej_d        = 1'b0;
        pcnt_d       = pcnt_q;
        clr_cnt_d    = clr_cnt_q;
        settle_cnt_d = settle_cnt_q;

        if (abort) begin
            state_d = S_IDLE;
        end else begin
            if (state_q != S_IDLE) begin
                rej_d = start_meas | start_read;
            end
            case (state_q)
                S_IDLE: begin
                    if (start_meas) begin
                        state_d      = S_CLEAR;
                        clear_d      = 1'b1;
                        pcnt_d       = '0;
                        clr_cnt_d    = '0;
                        settle_cnt_d = '0;
                    end else if (start_read) begin
                        if (!fifo_empty) begin
                            state_d = S_READ;
                            rd_d    = 1'b1;
                        end else begin
                            rej_d = 1'b1;
                        end
                    end
                end
                S_CLEAR: begin
                    if (clr_cnt_q == CLR_LAST) begin
                        state_d = S_SETTLE;
                    end else begin
                        clear_d   = 1'b1;
                        clr_cnt_d = clr_cnt_q + CLW'(1);
                    end
                end
                S_SETTLE: begin
                    // Start writing on a rising edge so wr_en moves while the conv clock is high
                    if (settle_cnt_q == SETTLE_N) begin
                        if (conv_rise) begin
                            state_d = S_CAPTURE;
                            wr_d    = 1'b1;
                        end
                    end else if (conv_fall) begin
                        settle_cnt_d = settle_cnt_q + SW'(1);
                    end
                end
                S_CAPTURE: begin
                    wr_d = 1'b1;
                    if ((pcnt_q == MEAS_MAX) || (fifo_full && wr_q)) begin
                        wr_d    = 1'b0;
                        done_d  = 1'b1;
                        state_d = S_DONE;
                    end else if (conv_fall) begin
                        pcnt_d = pcnt_inc;
                    end
                end
                S_DONE: begin
                    state_d = S_IDLE;
                end
                S_READ: begin
                    if (fifo_empty) begin
                        state_d = S_IDLE;
                    end else begin
                        rd_d = 1'b1;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
        busy_d = (state_d != S_IDLE);
    end

    // State and output registers
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            clear_q      <= 1'b0;
            wr_q         <= 1'b0;
            rd_q         <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            rej_q        <= 1'b0;
            pcnt_q       <= '0;
            clr_cnt_q    <= '0;
            settle_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            clear_q      <= clear_d;
            wr_q         <= wr_d;
            rd_q         <= rd_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            rej_q        <= rej_d;
            pcnt_q       <= pcnt_d;
            clr_cnt_q    <= clr_cnt_d;
            settle_cnt_q <= settle_cnt_d;
        end
    end

    assign fifo_clear   = clear_q;
    assign fifo_wr_en   = wr_q;
    assign fifo_rd_en   = rd_q;
    assign busy         = busy_q;
    assign meas_done    = done_q;
    assign cmd_rejected = rej_q;
    assign point_cnt    = pcnt_q;

endmodule
